// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame geometry.
// Both the receiver and the transmitter import this package.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk enable pulse every brd clocks.
// This block produces a clock enable only; no clock is derived from it.
module baud_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] brd,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] limit;

  // brd of 0 is treated as 1; >= lets a smaller brd take effect at once.
  always_comb limit = (brd == 16'd0) ? 16'd0 : brd - 16'd1;

  assign tick = (cnt >= limit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes rx, samples mid-bit on oversample ticks and
// presents each byte with ready, framing-error and overrun status.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          brd,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 tick;
  logic                 rx_meta, rx_s;
  uart_state_e          state, state_next;
  logic [SW-1:0]        sample_cnt, sample_cnt_next;
  logic [BW-1:0]        bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 load_good, load_bad;

  baud_tick_gen u_tick (
    .clk   (clk),
    .reset (reset),
    .brd   (brd),
    .tick  (tick)
  );

  // Synchronizer resets to the idle-high line level so reset cannot fake a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
    end else begin
      state      <= state_next;
      sample_cnt <= sample_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    sample_cnt_next = sample_cnt;
    bit_idx_next    = bit_idx;
    shift_next      = shift_reg;
    load_good       = 1'b0;
    load_bad        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next      = ST_START;
          sample_cnt_next = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sample_cnt == MID_CNT) begin
            sample_cnt_next = '0;
            bit_idx_next    = '0;
            state_next      = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            sample_cnt_next = sample_cnt + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (sample_cnt == LAST_CNT) begin
            sample_cnt_next = '0;
            shift_next      = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state_next = ST_STOP;
            else                     bit_idx_next = bit_idx + BW'(1);
          end else begin
            sample_cnt_next = sample_cnt + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sample_cnt == LAST_CNT) begin
            sample_cnt_next = '0;
            load_good       = rx_s;
            load_bad        = !rx_s;
            state_next      = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            sample_cnt_next = sample_cnt + SW'(1);
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A completed good byte wins over a same-cycle acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= load_bad;
      if (load_good || load_bad) data_out <= shift_reg;
      if (rx_ready && rd_ack) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end
      if (load_good) begin
        rx_ready <= 1'b1;
        if (rx_ready && !rd_ack) overrun <= 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: a table of frames plus hand-written
// sequences for false start, break, overrun, ack collision and mid-frame reset.
module tb_uart_rx_deserializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] brd;
  logic        rx;
  logic        rd_ack;
  logic [7:0]  data_out;
  logic        rx_ready;
  logic        framing_err;
  logic        overrun;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int ready_at, ferr_at, ferr_cnt;
  int busy_low_cnt, extra_ferr, ready_seen;

  typedef struct {
    logic [15:0] brd;
    logic [7:0]  data;
    logic        stop;
    logic [7:0]  exp_data;
    logic        exp_ready;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx_deserializer dut (
    .clk         (clk),
    .reset       (reset),
    .brd         (brd),
    .rx          (rx),
    .rd_ack      (rd_ack),
    .data_out    (data_out),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int eff_brd(input logic [15:0] b);
    return (b == 16'd0) ? 1 : int'(b);
  endfunction

  // Drives one frame; index i counts negedges since the stop bit was driven.
  // The stop bit is left on the line when the task returns.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic [15:0] b,
                            input int ack_at, output int r_at, output int f_at,
                            output int f_cnt);
    int         bclk;
    logic [8:0] bits;
    logic       prev_ready;
    bclk  = 16 * eff_brd(b);
    bits  = {d, 1'b0};
    r_at  = -1;
    f_at  = -1;
    f_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      rx = bits[k];
      repeat (bclk) begin
        @(negedge clk);
        if (framing_err) f_cnt++;
      end
    end
    rx = stop;
    prev_ready = rx_ready;
    for (int i = 1; i <= bclk; i++) begin
      @(negedge clk);
      if (framing_err) begin
        f_cnt++;
        if (f_at < 0) f_at = i;
      end
      if (rx_ready && !prev_ready && r_at < 0) r_at = i;
      prev_ready = rx_ready;
      rd_ack = (i == ack_at);
    end
    rd_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    rd_ack = 1'b0;
    brd    = 16'd4;

    vecs[0] = '{16'd4, 8'hA5, 1'b1, 8'hA5, 1'b1, 0};
    vecs[1] = '{16'd0, 8'h81, 1'b1, 8'h81, 1'b1, 0};
    vecs[2] = '{16'd2, 8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[3] = '{16'd1, 8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[4] = '{16'd3, 8'h96, 1'b0, 8'h96, 1'b0, 1};
    vecs[5] = '{16'd4, 8'h5A, 1'b1, 8'h5A, 1'b1, 0};

    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_framing_err", 32'(framing_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Result visible 7*brd+3 .. 8*brd+4 negedges after the stop bit starts.
    for (int v = 0; v < 6; v++) begin
      brd = vecs[v].brd;
      repeat (4) @(negedge clk);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].brd, -1, ready_at, ferr_at, ferr_cnt);
      check($sformatf("vec%0d_data_out", v), 32'(data_out), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_rx_ready", v), 32'(rx_ready), 32'(vecs[v].exp_ready));
      check($sformatf("vec%0d_ferr_pulses", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'h0);
      if (vecs[v].exp_ready)
        check_range($sformatf("vec%0d_ready_latency", v), ready_at,
                    7 * eff_brd(vecs[v].brd) + 3, 8 * eff_brd(vecs[v].brd) + 4);
      else
        check_range($sformatf("vec%0d_ferr_latency", v), ferr_at,
                    7 * eff_brd(vecs[v].brd) + 3, 8 * eff_brd(vecs[v].brd) + 4);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'h0);
      pulse_ack();
      check($sformatf("vec%0d_ack_clears", v), 32'(rx_ready), 32'h0);
    end

    // False start: 20 clk low pulse is gone by the mid-start sample.
    brd = 16'd4;
    repeat (8) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("false_start_busy_high", 32'(busy), 32'h1);
    repeat (17) @(negedge clk);
    rx = 1'b1;
    extra_ferr = 0;
    ready_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (framing_err) extra_ferr++;
      if (rx_ready) ready_seen++;
    end
    check("false_start_busy_low", 32'(busy), 32'h0);
    check("false_start_no_ready", 32'(ready_seen), 32'h0);
    check("false_start_no_ferr", 32'(extra_ferr), 32'h0);
    check("false_start_data_held", 32'(data_out), 32'h5A);

    // Break: bad stop bit, then line held low; FSM must sit in WAIT_HIGH.
    send_frame(8'h3C, 1'b0, 16'd4, -1, ready_at, ferr_at, ferr_cnt);
    busy_low_cnt = 0;
    extra_ferr   = 0;
    repeat (200) begin
      @(negedge clk);
      if (!busy) busy_low_cnt++;
      if (framing_err) extra_ferr++;
    end
    check("break_ferr_pulses", 32'(ferr_cnt), 32'h1);
    check("break_data_out", 32'(data_out), 32'h3C);
    check("break_rx_ready", 32'(rx_ready), 32'h0);
    check("break_busy_held", 32'(busy_low_cnt), 32'h0);
    check("break_no_retrigger_ferr", 32'(extra_ferr), 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("break_release_busy", 32'(busy), 32'h0);

    // Overrun: second byte lands with rx_ready still set.
    send_frame(8'h11, 1'b1, 16'd4, -1, ready_at, ferr_at, ferr_cnt);
    check("ovr_first_ready", 32'(rx_ready), 32'h1);
    check("ovr_first_overrun", 32'(overrun), 32'h0);
    send_frame(8'h22, 1'b1, 16'd4, -1, ready_at, ferr_at, ferr_cnt);
    check("ovr_data_out", 32'(data_out), 32'h22);
    check("ovr_rx_ready", 32'(rx_ready), 32'h1);
    check("ovr_overrun", 32'(overrun), 32'h1);
    pulse_ack();
    check("ovr_ack_ready", 32'(rx_ready), 32'h0);
    check("ovr_ack_overrun", 32'(overrun), 32'h0);

    // Ack in the load cycle: with brd=0 the load edge follows negedge 10 of the stop bit.
    brd = 16'd0;
    repeat (4) @(negedge clk);
    send_frame(8'h33, 1'b1, 16'd0, -1, ready_at, ferr_at, ferr_cnt);
    check("collide_first_ready", 32'(rx_ready), 32'h1);
    send_frame(8'h44, 1'b1, 16'd0, 10, ready_at, ferr_at, ferr_cnt);
    check("collide_data_out", 32'(data_out), 32'h44);
    check("collide_rx_ready", 32'(rx_ready), 32'h1);
    check("collide_overrun", 32'(overrun), 32'h0);

    // Reset during data bit 3 of 0xFF, with rx_ready still high from above.
    brd = 16'd4;
    repeat (4) @(negedge clk);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (64 * 3 + 20) @(negedge clk);
    check("midreset_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("midreset_data_out", 32'(data_out), 32'h0);
    check("midreset_rx_ready", 32'(rx_ready), 32'h0);
    check("midreset_framing_err", 32'(framing_err), 32'h0);
    check("midreset_overrun", 32'(overrun), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ready_seen = 0;
    extra_ferr = 0;
    repeat (400) begin
      @(negedge clk);
      if (rx_ready) ready_seen++;
      if (framing_err) extra_ferr++;
    end
    check("postreset_idle_busy", 32'(busy), 32'h0);
    check("postreset_no_ready", 32'(ready_seen), 32'h0);
    check("postreset_no_ferr", 32'(extra_ferr), 32'h0);
    send_frame(8'h5A, 1'b1, 16'd4, -1, ready_at, ferr_at, ferr_cnt);
    check("postreset_data_out", 32'(data_out), 32'h5A);
    check("postreset_rx_ready", 32'(rx_ready), 32'h1);
    check("postreset_ferr", 32'(ferr_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
